// File: rtl/muldiv_pkg.sv
// Shared constants, opcode encodings and FSM states for the EX-stage multiply/divide unit.
// MULDIV_MADD_EN widens the accepted opcode set to include MADD/MADDU/MSUB/MSUBU.
package muldiv_pkg;

    localparam int WIDTH = 32;
    localparam int ITERS = 32;
    localparam int CNT_W = $clog2(ITERS);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    function automatic logic is_acc_op(input logic [3:0] op);
        return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_sub_op(input logic [3:0] op);
        return (op == OP_MSUB) || (op == OP_MSUBU);
    endfunction

    function automatic logic is_mul_op(input logic [3:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MULDIV_MADD_EN
        r = r || is_acc_op(op);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step on a {hi,lo} pair.
// Zero latency; no flow control, sequenced entirely by the owning FSM.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic             div_mode,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Multiply: lo holds the remaining multiplier bits, product shifts in from the top.
    assign sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

    // Divide: lo holds the dividend bits being consumed and the quotient bits being formed.
    // The remainder always stays below opnd, so a 32-bit difference is exact when ge is set.
    assign shifted = {hi, lo[WIDTH-1]};
    assign ge      = shifted >= {1'b0, opnd};
    assign diff    = shifted[WIDTH-1:0] - opnd;

    always_comb begin
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
        if (div_mode) begin
            hi_next = ge ? diff : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], ge};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage mul/div with private HI/LO; 33 busy cycles per op, Done the cycle after writeback.
// Stall holds ID/EX while busy; MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulation.
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ReadHiLo,
    input  logic             Flush,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic             DivZero
);

    state_t state, state_nxt;

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [3:0]       op_q;
    logic             sign_a, sign_b;
    logic             done_q, divz_q;

    logic             accept;
    logic             op_mul, op_div, op_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             last_step;

    logic             neg_res;
    logic [2*WIDTH-1:0] prod_val, fix_hilo;
    logic [WIDTH-1:0] quot, rem;

    assign op_mul    = is_mul_op(Op);
    assign op_div    = is_div_op(Op);
    assign op_signed = is_signed_op(Op);
    assign a_neg     = op_signed & A[WIDTH-1];
    assign b_neg     = op_signed & B[WIDTH-1];
    assign mag_a     = magnitude(A, a_neg);
    assign mag_b     = magnitude(B, b_neg);
    assign last_step = (count == CNT_W'(ITERS - 1));

    // Busy is zero in IDLE, so Stall can never block an op that IDLE would accept.
    assign Busy    = (state != ST_IDLE);
    assign Stall   = Busy & (Start | ReadHiLo);
    assign accept  = (state == ST_IDLE) && Start && !Flush;
    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign Done    = done_q;
    assign DivZero = divz_q;

    muldiv_step u_step (
        .div_mode (state == ST_DIV),
        .hi       (acc_hi),
        .lo       (acc_lo),
        .opnd     (opnd),
        .hi_next  (step_hi),
        .lo_next  (step_lo)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept && op_mul) begin
                    state_nxt = ST_MUL;
                end else if (accept && op_div && (B != '0)) begin
                    state_nxt = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_step) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: state_nxt = ST_IDLE;
        endcase
        if (Flush) begin
            state_nxt = ST_IDLE;
        end
    end

    // Sign fix-up: magnitudes were iterated, so only the final result needs correcting.
    assign neg_res  = sign_a ^ sign_b;
    assign prod_val = neg_res ? (~{acc_hi, acc_lo} + (2*WIDTH)'(1)) : {acc_hi, acc_lo};
    assign quot     = neg_res ? (~acc_lo + WIDTH'(1)) : acc_lo;
    assign rem      = sign_a ? (~acc_hi + WIDTH'(1)) : acc_hi;

    always_comb begin
        fix_hilo = prod_val;
        if (is_div_op(op_q)) begin
            fix_hilo = {rem, quot};
        end
`ifdef MULDIV_MADD_EN
        else if (is_acc_op(op_q)) begin
            fix_hilo = is_sub_op(op_q) ? ({hi_q, lo_q} - prod_val) : ({hi_q, lo_q} + prod_val);
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            op_q   <= OP_NOP;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            count  <= '0;
            done_q <= 1'b0;
            divz_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            divz_q <= 1'b0;
            if (Flush) begin
                count <= '0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            count  <= '0;
                            op_q   <= Op;
                            sign_a <= a_neg;
                            sign_b <= b_neg;
                            acc_hi <= '0;
                            if (op_mul) begin
                                acc_lo <= mag_b;
                                opnd   <= mag_a;
                            end else if (op_div) begin
                                acc_lo <= mag_a;
                                opnd   <= mag_b;
                                divz_q <= (B == '0);
                            end
                            if (Op == OP_MTHI) hi_q <= A;
                            if (Op == OP_MTLO) lo_q <= A;
                        end
                    end
                    ST_MUL, ST_DIV: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count + CNT_W'(1);
                    end
                    ST_FIX: begin
                        hi_q   <= fix_hilo[2*WIDTH-1:WIDTH];
                        lo_q   <= fix_hilo[WIDTH-1:0];
                        done_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results queue on issue, a negedge monitor checks each Done/DivZero.
// Honours MULDIV_MADD_EN to pick the expected MADDU behaviour.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        Clk, Reset, Start, ReadHiLo, Flush;
    logic [3:0]  Op;
    logic [31:0] A, B, Hi, Lo;
    logic        Busy, Stall, Done, DivZero;

    typedef struct {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    ex_muldiv_unit dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Op       (Op),
        .A        (A),
        .B        (B),
        .ReadHiLo (ReadHiLo),
        .Flush    (Flush),
        .Hi       (Hi),
        .Lo       (Lo),
        .Busy     (Busy),
        .Stall    (Stall),
        .Done     (Done),
        .DivZero  (DivZero)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_result(input logic dz, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.dz = dz;
        e.hi = hi;
        e.lo = lo;
        sb.push_back(e);
    endtask

    // Monitor: every Done or DivZero pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Reset !== 1'b1 && (Done === 1'b1 || DivZero === 1'b1)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: Done=%0b DivZero=%0b Hi=0x%h Lo=0x%h, none expected",
                             Done, DivZero, Hi, Lo);
                end else begin
                    e = sb.pop_front();
                    check("sb_flags", 64'({DivZero, Done}), 64'({e.dz, ~e.dz}));
                    check("sb_hilo", {Hi, Lo}, {e.hi, e.lo});
                end
            end
        end
    end

    // Holds the op in EX until the unit accepts it; returns one time unit after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        Start  = 1'b1;
        Op     = op;
        A      = a;
        B      = b;
        stalls = 0;
        @(negedge Clk);
        while (Stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(negedge Clk);
        end
        if (stalls >= 100) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: op %0d still stalled after %0d cycles", op, stalls);
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        Op    = OP_NOP;
    endtask

    task automatic wait_done(output int busy_cyc, output int done_at);
        busy_cyc = 0;
        done_at  = 0;
        for (int i = 1; i <= 80; i++) begin
            @(negedge Clk);
            if (Busy === 1'b1) busy_cyc++;
            if (Done === 1'b1) begin
                done_at = i;
                break;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int s, s2, busy_cyc, done_at;
        logic busy_seen;

        Reset = 1'b1; Start = 1'b0; Op = OP_NOP; A = '0; B = '0;
        ReadHiLo = 1'b1; Flush = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_hilo", {Hi, Lo}, 64'd0);
        check("reset_flags", 64'({Busy, Stall, Done, DivZero}), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        ReadHiLo = 1'b0;

        // Unsigned max x max, with latency measurement.
        expect_result(1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
        wait_done(busy_cyc, done_at);
        check("multu_busy_cycles", 64'(busy_cyc), 64'd33);
        check("multu_done_cycle", 64'(done_at), 64'd34);

        // Signed divide with dependent MFHI right behind it.
        expect_result(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, s);
        ReadHiLo = 1'b1;
        s = 0;
        @(negedge Clk);
        while (Stall === 1'b1 && s < 80) begin
            s++;
            @(negedge Clk);
        end
        check("mfhi_stall_cycles", 64'(s), 64'd33);
        check("mfhi_sees_done", 64'(Done), 64'd1);
        check("mfhi_hi", 64'(Hi), 64'hFFFF_FFFF);
        @(posedge Clk);
        #1;
        ReadHiLo = 1'b0;

        expect_result(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, s);
        wait_done(busy_cyc, done_at);
        check("mult_neg_done_cycle", 64'(done_at), 64'd34);

        expect_result(1'b0, 32'h0000_0000, 32'h8000_0000);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s);
        wait_done(busy_cyc, done_at);

        expect_result(1'b0, 32'h0000_0001, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE, s);
        wait_done(busy_cyc, done_at);

        // MTHI/MTLO are visible the cycle after acceptance and never raise Busy.
        issue(OP_MTHI, 32'h11, 32'h0, s);
        @(negedge Clk);
        check("mthi_visible", 64'({Hi, Busy}), 64'({32'h11, 1'b0}));
        @(posedge Clk);
        #1;
        issue(OP_MTLO, 32'h22, 32'h0, s);
        @(negedge Clk);
        check("mtlo_visible", {Hi, Lo}, {32'h11, 32'h22});
        @(posedge Clk);
        #1;

        // Divide by zero: pulse only, HI/LO untouched, never busy.
        expect_result(1'b1, 32'h11, 32'h22);
        issue(OP_DIVU, 32'd5, 32'd0, s);
        @(negedge Clk);
        check("divzero_pulse", 64'({DivZero, Busy}), 64'({1'b1, 1'b0}));
        busy_seen = Busy;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            busy_seen = busy_seen | Busy;
        end
        check("divzero_never_busy", 64'(busy_seen), 64'd0);
        check("divzero_hilo", {Hi, Lo}, {32'h11, 32'h22});
        @(posedge Clk);
        #1;

        // Flush mid-multiply: back to IDLE, nothing written, no Done.
        issue(OP_MULT, 32'd5, 32'd3, s);
        repeat (9) @(posedge Clk);
        #1;
        Flush = 1'b1;
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        @(negedge Clk);
        check("flush_idle", 64'(Busy), 64'd0);
        repeat (40) @(negedge Clk);
        check("flush_hilo", {Hi, Lo}, {32'h11, 32'h22});
        @(posedge Clk);
        #1;

        // Reset partway through a divide.
        issue(OP_DIV, 32'd100, 32'd7, s);
        repeat (19) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_mid_div", 64'({Hi, Lo}), 64'd0);
        check("reset_mid_div_busy", 64'(Busy), 64'd0);
        @(posedge Clk);
        #1;

        // Accumulating multiply: carry out of LO into HI, or ignored when the feature is off.
        issue(OP_MTHI, 32'h0, 32'h0, s);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0, s);
`ifdef MULDIV_MADD_EN
        expect_result(1'b0, 32'h1, 32'h0);
        issue(OP_MADDU, 32'd1, 32'd1, s);
        wait_done(busy_cyc, done_at);
        check("maddu_done_cycle", 64'(done_at), 64'd34);
`else
        issue(OP_MADDU, 32'd1, 32'd1, s);
        @(negedge Clk);
        check("maddu_ignored_busy", 64'(Busy), 64'd0);
        repeat (40) @(negedge Clk);
        check("maddu_ignored_hilo", {Hi, Lo}, {32'h0, 32'hFFFF_FFFF});
        @(posedge Clk);
        #1;
`endif

        // Back-to-back multiplies: the second waits out the first.
        expect_result(1'b0, 32'h0, 32'd6);
        expect_result(1'b0, 32'h0, 32'd20);
        issue(OP_MULT, 32'd2, 32'd3, s);
        issue(OP_MULT, 32'd4, 32'd5, s2);
        check("b2b_stall_cycles", 64'(s2), 64'd33);
        wait_done(busy_cyc, done_at);
        check("b2b_second_done_cycle", 64'(done_at), 64'd34);

        repeat (5) @(posedge Clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
